// File: rtl/ssp_pkg.sv
// Shared SSP definitions: sequencer state encoding and default frame length.
// Used by the transmit controller and the receive controller.
package ssp_pkg;

    localparam int SSP_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FRAME = 2'd2,
        SHIFT = 2'd3
    } ssp_state_t;

endpackage

// File: rtl/ssp_clk_div.sv
// SSP serial clock divider: toggles sclk every CLK_DIV cycles while run_i is high.
// Latency: sclk_o is registered; the strobes flag the cycle before each toggle.
// Backpressure: none; clr_i/rst_i force sclk low and restart the half period.
module ssp_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             sclk;
    logic             half_end;

    assign half_end   = run_i && (div_cnt == DIV_LAST);
    assign rise_stb_o = half_end && !sclk;
    assign fall_stb_o = half_end && sclk;
    assign sclk_o     = sclk;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (run_i) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit sequencer: load strobe, frame sync, SSPCLK and shift strobes, MSB first.
// Latency: sr_ld_o one cycle after accept; tx_done_o (DATA_W+1)*2*CLK_DIV cycles after that.
// Backpressure: tx_ready_o only in IDLE or the last frame cycle, gated by en_i; nothing is queued.
module ssp_tx_ctrl
    import ssp_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = SSP_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] sr_d_o,
    output logic              sr_ld_o,
    output logic              sr_shift_o,
    output logic              sspclkout_o,
    output logic              sspfssout_o,
    output logic              ssp_oe_o,
    output logic              busy_o,
    output logic              tx_done_o
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    ssp_state_t       state;
    ssp_state_t       state_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic             div_clr;
    logic             div_run;
    logic             sclk;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             last_bit;
    logic             handshake;

    // Divider is held cleared outside the serial phases so every frame starts at a fresh half period.
    assign div_clr = (state == IDLE) || (state == LOAD);
    assign div_run = (state == FRAME) || (state == SHIFT);

    ssp_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (div_clr),
        .run_i      (div_run),
        .sclk_o     (sclk),
        .rise_stb_o (sclk_rise),
        .fall_stb_o (sclk_fall)
    );

    assign last_bit    = (state == SHIFT) && sclk_fall && (bit_cnt == BIT_LAST);
    assign tx_ready_o  = en_i && ((state == IDLE) || last_bit);
    assign handshake   = tx_valid_i && tx_ready_o;
    assign busy_o      = (state != IDLE);
    assign sspclkout_o = sclk;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_d_o <= '0;
        end else if (handshake) begin
            sr_d_o <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (state == LOAD)) begin
            bit_cnt <= '0;
        end else if ((state == SHIFT) && sclk_fall) begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        sr_ld_o     = 1'b0;
        sr_shift_o  = 1'b0;
        sspfssout_o = 1'b0;
        ssp_oe_o    = 1'b0;
        tx_done_o   = 1'b0;
        unique case (state)
            IDLE: begin
                if (handshake) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sr_ld_o   = 1'b1;
                state_nxt = FRAME;
            end
            FRAME: begin
                sspfssout_o = 1'b1;
                ssp_oe_o    = 1'b1;
                if (sclk_fall) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ssp_oe_o   = 1'b1;
                // Shift on the cycle before sclk falls so data changes on the falling edge.
                sr_shift_o = sclk_fall;
                if (last_bit) begin
                    tx_done_o = 1'b1;
                    state_nxt = handshake ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    a_rise_while_driving: assert property (@(posedge clk_i) disable iff (rst_i)
        sclk_rise |-> ssp_oe_o);

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Bench for ssp_tx_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) share one stimulus stream.
// A timing model derived from the handshake cycle predicts every output each cycle.
module tb_ssp_tx_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic       ready;
        logic [7:0] d;
        logic       ld;
        logic       shift;
        logic       sclk;
        logic       fss;
        logic       oe;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       busy;
        logic       ld;
        logic [7:0] d;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, vld;
    logic [7:0] dat;

    logic       a_rdy, a_ld, a_sh, a_sclk, a_fss, a_oe, a_busy, a_done;
    logic [7:0] a_d;
    logic       b_rdy, b_ld, b_sh, b_sclk, b_fss, b_oe, b_busy, b_done;
    logic [7:0] b_d;

    ssp_tx_ctrl #(.CLK_DIV(2), .DATA_W(W)) u_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .tx_data_i(dat), .tx_valid_i(vld),
        .tx_ready_o(a_rdy), .sr_d_o(a_d), .sr_ld_o(a_ld), .sr_shift_o(a_sh),
        .sspclkout_o(a_sclk), .sspfssout_o(a_fss), .ssp_oe_o(a_oe),
        .busy_o(a_busy), .tx_done_o(a_done)
    );

    ssp_tx_ctrl #(.CLK_DIV(1), .DATA_W(W)) u_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .tx_data_i(dat), .tx_valid_i(vld),
        .tx_ready_o(b_rdy), .sr_d_o(b_d), .sr_ld_o(b_ld), .sr_shift_o(b_sh),
        .sspclkout_o(b_sclk), .sspfssout_o(b_fss), .ssp_oe_o(b_oe),
        .busy_o(b_busy), .tx_done_o(b_done)
    );

    out_t act [2];
    assign act[0] = {a_rdy, a_d, a_ld, a_sh, a_sclk, a_fss, a_oe, a_busy, a_done};
    assign act[1] = {b_rdy, b_d, b_ld, b_sh, b_sclk, b_fss, b_oe, b_busy, b_done};

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    int cyc = 0;

    bit         m_have [2];
    int         m_t0   [2];
    logic [7:0] m_d    [2];
    logic [7:0] sq     [2];
    logic [7:0] bits   [2];
    int         nb     [2];
    logic       prev_sclk [2];
    out_t       exp_o;

    // Expected outputs in cycle c for a frame accepted in cycle t0, from the frame timeline alone.
    function automatic out_t model_out(input bit have, input int t0, input int c, input int dv,
                                       input logic en_now, input logic [7:0] dreg);
        out_t e;
        int   len;
        int   o;
        e   = '0;
        e.d = dreg;
        len = 1 + (W + 1) * 2 * dv;
        o   = c - t0;
        if (have && o >= 1 && o <= len) begin
            e.busy = 1'b1;
            if (o == 1) begin
                e.ld = 1'b1;
            end else begin
                e.oe   = 1'b1;
                e.sclk = (((o - 2) / dv) % 2) == 1;
                if (o <= 1 + 2 * dv) e.fss = 1'b1;
                else if (((o - 2) % (2 * dv)) == 2 * dv - 1) e.shift = 1'b1;
                if (o == len) e.done = 1'b1;
            end
        end
        e.ready = en_now && !(e.busy && !e.done);
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                exp_o = model_out(m_have[i], m_t0[i], cyc, (i == 0) ? 2 : 1, en, m_d[i]);
                n_vec++;
                if (act[i] !== exp_o) begin
                    n_err++;
                    $display("FAIL model dut%0d cyc%0d: got %h want %h (rdy,d,ld,sh,sclk,fss,oe,busy,done)",
                             i, cyc, act[i], exp_o);
                end
                // Downstream shift register, sampled on each rising sclk after frame sync.
                if (act[i].oe && !act[i].fss && act[i].sclk && !prev_sclk[i]) begin
                    bits[i] = {bits[i][6:0], sq[i][7]};
                    nb[i]++;
                end
                if (act[i].done) begin
                    n_vec++;
                    if (nb[i] != W || bits[i] !== m_d[i]) begin
                        n_err++;
                        $display("FAIL serial dut%0d cyc%0d: got %0d bits %h want 8 bits %h",
                                 i, cyc, nb[i], bits[i], m_d[i]);
                    end
                end
                if (act[i].ld) begin
                    sq[i] = act[i].d;
                    nb[i] = 0;
                end else if (act[i].shift) begin
                    sq[i] = {sq[i][6:0], 1'b0};
                end
                prev_sclk[i] = act[i].sclk;
                if (rst) begin
                    m_have[i] = 1'b0;
                    m_d[i]    = 8'h00;
                    nb[i]     = 0;
                end else if (vld && exp_o.ready) begin
                    m_have[i] = 1'b1;
                    m_t0[i]   = cyc;
                    m_d[i]    = dat;
                end
            end
            cyc++;
        end
    end

    task automatic drive(input logic r, input logic e, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        vld = v;
        dat = d;
    endtask

    task automatic hold(input int n);
        repeat (n) drive(1'b0, en, 1'b0, 8'h00);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One frame accepted in cycle T; checks landmark cycles of both divider settings.
    task automatic single_frame(input logic [7:0] b);
        drive(1'b0, 1'b1, 1'b1, b);
        hold(1);  #3; chk("ld_a", a_ld, 8'h01); chk("d_a", a_d, b); chk("ld_b", b_ld, 8'h01);
        hold(3);  #3; chk("sclk_rise_a", a_sclk, 8'h01); chk("fss_a", a_fss, 8'h01);
        hold(1);  #3; chk("shift0_b", b_sh, 8'h01);
        hold(1);  #3; chk("sclk_fall_a", a_sclk, 8'h00); chk("fss_end_a", a_fss, 8'h00);
                      chk("oe_a", a_oe, 8'h01);
        hold(3);  #3; chk("shift0_a", a_sh, 8'h01);
        hold(10); #3; chk("done_b", b_done, 8'h01);
        hold(18); #3; chk("done_a", a_done, 8'h01);
        hold(3);
    endtask

    vec_t tbl [9];
    int   n_sh;
    bit   busy_ok;

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; dat = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m_have[i] = 1'b0; m_t0[i] = 0; m_d[i] = 8'h00; sq[i] = 8'h00;
            bits[i] = 8'h00; nb[i] = 0; prev_sclk[i] = 1'b0;
        end
        //          rst   en    vld   dat     rdy   busy  ld    d
        tbl[0] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 8'h3C};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

        @(posedge clk);
        #1;
        chk_on = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].dat);
            #3;
            chk($sformatf("tbl%0d_ready", i), a_rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_ld", i), a_ld, tbl[i].ld);
            chk($sformatf("tbl%0d_d", i), a_d, tbl[i].d);
        end

        single_frame(8'h5A);

        // Back-to-back frames with valid held through the first one.
        drive(1'b0, 1'b1, 1'b1, 8'h5A);
        n_sh = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            drive(1'b0, 1'b1, (k <= 37), 8'hA5);
            #3;
            if (a_sh === 1'b1) n_sh++;
            if (a_busy !== 1'b1) busy_ok = 1'b0;
            if (k == 37) begin
                chk("b2b_done_a", a_done, 8'h01);
                chk("b2b_ready_a", a_rdy, 8'h01);
            end
            if (k == 38) begin
                chk("b2b_ld_a", a_ld, 8'h01);
                chk("b2b_d_a", a_d, 8'hA5);
            end
        end
        chk("b2b_shifts_a", 8'(n_sh), 8'd16);
        chk("b2b_busy_a", {7'd0, busy_ok}, 8'h01);
        hold(25);

        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h3C);
            #3;
            chk("en0_ready_a", a_rdy, 8'h00);
            chk("en0_ld_a", a_ld, 8'h00);
            chk("en0_busy_b", b_busy, 8'h00);
        end

        // Enable dropped at bit 3: the frame still completes, nothing new starts.
        drive(1'b0, 1'b1, 1'b1, 8'h96);
        n_sh = 0;
        for (int k = 1; k <= 40; k++) begin
            drive(1'b0, (k < 18), 1'b1, 8'h69);
            #3;
            if (a_sh === 1'b1) n_sh++;
            if (k == 37) begin
                chk("endrop_done_a", a_done, 8'h01);
                chk("endrop_ready_a", a_rdy, 8'h00);
            end
            if (k == 38) begin
                chk("endrop_idle_a", a_busy, 8'h00);
                chk("endrop_noload_a", a_ld, 8'h00);
            end
        end
        chk("endrop_shifts_a", 8'(n_sh), 8'd8);
        hold(2);

        // One-cycle reset at bit 3 aborts the frame.
        drive(1'b0, 1'b1, 1'b1, 8'h77);
        hold(17);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        #3;
        chk("abort_busy_a", a_busy, 8'h00);
        chk("abort_sclk_a", a_sclk, 8'h00);
        chk("abort_oe_a", a_oe, 8'h00);
        chk("abort_fss_a", a_fss, 8'h00);
        chk("abort_d_a", a_d, 8'h00);
        chk("abort_ready_a", a_rdy, 8'h01);
        chk("abort_busy_b", b_busy, 8'h00);
        single_frame(8'hC3);

        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) != 0),
                  $urandom_range(0, 1) == 1, 8'($urandom));
        end
        hold(45);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ssp_tx_ctrl.md
Name: ssp_tx_ctrl

Overview:
Transmit sequencer for the SSP module. It accepts bytes over a valid/ready handshake and drives the parallel-load and shift strobes of the 8-bit transmit shift register (shift_reg_tx). It generates the SSP serial clock, the TI-style frame-sync pulse and the output enable, so serial data leaves MSB-first, one bit per SSPCLK period. It sits between the SSP register/FIFO front end and shift_reg_tx.

Parameters:
CLK_DIV, 2, number of clk_i cycles per SSPCLK half-period; must be >= 1.
DATA_W, 8, frame length in bits; must match the shift register width.

Ports:
clk_i  in  1  system clock, all logic on the rising edge
rst_i  in  1  synchronous, active-high reset
en_i  in  1  SSP enable; when low no new frame starts
tx_data_i  in  DATA_W  byte to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  controller accepts tx_data_i this cycle
sr_d_o  out  DATA_W  parallel data to shift register d_in
sr_ld_o  out  1  shift register load strobe, one cycle
sr_shift_o  out  1  shift register shift strobe, one cycle per bit
sspclkout_o  out  1  serial clock, idle low
sspfssout_o  out  1  frame sync, high for exactly one SSPCLK period before the MSB
ssp_oe_o  out  1  serial data output enable, high during FRAME and SHIFT
busy_o  out  1  high in any state other than IDLE
tx_done_o  out  1  one-cycle pulse in the last cycle of a frame

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE; sr_d_o=0; every 1-bit output=0 except tx_ready_o, which follows en_i combinationally in IDLE. A reset mid-frame aborts the frame on the next edge. No partial completion and no tx_done_o.
- A handshake occurs when tx_valid_i && tx_ready_o. On a handshake, tx_data_i is registered into sr_d_o. sr_d_o changes only on a handshake.
- States: IDLE, LOAD, FRAME, SHIFT.
- IDLE: tx_ready_o=en_i. A handshake moves the state to LOAD.
- LOAD: lasts 1 cycle with sr_ld_o=1, sclk=0 and fss=0. The next state is FRAME, and the divider counter clears.
- FRAME: lasts 2*CLK_DIV cycles with sspfssout_o=1 and ssp_oe_o=1. sclk is 0 for the first CLK_DIV cycles and 1 for the next CLK_DIV cycles. There is no shift strobe. The next state is SHIFT.
- SHIFT: lasts DATA_W*2*CLK_DIV cycles with ssp_oe_o=1 and the same sclk pattern per bit.
  - sr_shift_o=1 in the last cycle of each bit period (div_cnt==CLK_DIV-1 and sclk==1). This gives exactly DATA_W pulses, so data changes on the falling SSPCLK edge and is stable at the rising edge.
  - A bit counter counts from 0 to DATA_W-1 and wraps to 0 at the end of the frame.
- Last cycle of SHIFT:
  - tx_done_o=1 and tx_ready_o=en_i.
  - If a handshake occurs, the next state is LOAD (back-to-back transfer: one-cycle gap, sclk low, fss low). Otherwise the next state is IDLE.
- en_i deasserted mid-frame: the current frame completes normally, and no further handshake is accepted.
- tx_valid_i without tx_ready_o is ignored. No data is held pending.
- Latency (handshake in cycle T):
  - sr_ld_o at T+1.
  - FRAME covers T+2 to T+1+2*CLK_DIV.
  - tx_done_o at T+1+(DATA_W+1)*2*CLK_DIV.
- Counter widths: div_cnt is $clog2(CLK_DIV) bits (minimum 1 bit); bit_cnt is $clog2(DATA_W) bits.

Decomposition:
- ssp_pkg: the state enum (IDLE/LOAD/FRAME/SHIFT) and the SSP_DATA_W=8 constant. It is shared with the future receive controller.
- Sub-module ssp_clk_div:
  - Holds the half-period counter and the sclk toggle.
  - Has a synchronous clear and a run enable.
  - Outputs sclk, rise_stb and fall_stb (the cycle before each toggle).
  - The receive side reuses it.

Test Plan:
1. Reset with tx_valid_i=1 and en_i=1 held → during reset sr_ld_o=0, sr_shift_o=0, fss=0, oe=0, busy=0 and sr_d_o=0. After release, the first handshake occurs in the first IDLE cycle.
2. CLK_DIV=2, handshake 0x5A at T → sr_d_o=0x5A and sr_ld_o at T+1. fss=1 over T+2..T+5. sclk rises at T+4 and falls at T+6. sr_shift_o at T+9+4k for k=0..7. tx_done_o at T+37. The bench's shift_reg_tx model emits q = 0,1,0,1,1,0,1,0 sampled on the rising sclk edges.
3. 0x5A then 0xA5 with tx_valid_i held → second handshake at T+37, second sr_ld_o at T+38, busy_o never drops, 16 shift pulses in total.
4. en_i=0 with tx_valid_i=1 → tx_ready_o=0 and no strobes. Drop en_i at bit 3 of an active frame → the frame completes (8 shifts, tx_done_o), then IDLE with no new handshake.
5. Assert rst_i for 1 cycle at bit 3 → next cycle is IDLE with all outputs at reset values. A subsequent 0xC3 frame is timed exactly as in scenario 2.
6. CLK_DIV=1, byte 0xFF → bit period of 2 cycles; tx_done_o at T+19; sr_shift_o at T+5+2k.
